// File: rtl/pwm_ramp_gen_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_ramp_gen_pkg
//  Description : Shared types and constants for the ramped PWM generator.
//  Revision    : 1.0 - initial release
// ============================================================================
package pwm_ramp_gen_pkg;

    // Default width of the upstream counter and of every duty value
    localparam int CNT_W_DEF = 8;

    // Last counter value of a period at the default width
    localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

    // Duty-control state machine
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RAMP = 2'd1,
        ST_RUN  = 2'd2
    } state_t;

endpackage : pwm_ramp_gen_pkg
`default_nettype wire

// File: rtl/pwm_ramp_gen_if.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_ramp_gen_if
//  Description : valid/ready duty-target load channel. The producer owns
//                duty_in/duty_valid, the PWM block owns duty_ready.
//  Revision    : 1.0 - initial release
// ============================================================================
interface pwm_ramp_gen_if #(
    parameter int CNT_W = pwm_ramp_gen_pkg::CNT_W_DEF
) ();

    logic [CNT_W-1:0] duty_in;
    logic             duty_valid;
    logic             duty_ready;

    // Producer side
    modport master (
        output duty_in,
        output duty_valid,
        input  duty_ready
    );

    // PWM generator side
    modport slave (
        input  duty_in,
        input  duty_valid,
        output duty_ready
    );

endinterface : pwm_ramp_gen_if
`default_nettype wire

// File: rtl/pwm_ramp_gen_duty_ramp_step.sv
`default_nettype none
// ============================================================================
//  Module      : duty_ramp_step
//  Description : Combinational saturating step of the duty value toward its
//                target. Never overshoots and never wraps in either
//                direction; done flags that the step lands on the target.
//  Revision    : 1.0 - initial release
// ============================================================================
module duty_ramp_step #(
    parameter int CNT_W   = pwm_ramp_gen_pkg::CNT_W_DEF,
    parameter int RAMP_EN = 1
) (
    input  logic [CNT_W-1:0] cur,
    input  logic [CNT_W-1:0] tgt,
    input  logic [CNT_W-1:0] step,
    output logic [CNT_W-1:0] next,
    output logic             done
);

    // Upward sum keeps a carry bit so cur+step cannot wrap past the top
    logic [CNT_W:0]   w_up_sum;
    // Remaining distance when moving down (only meaningful when cur > tgt)
    logic [CNT_W-1:0] w_gap_dn;

    // Move one step toward tgt, clamping to tgt when the step would pass it
    always_comb begin
        w_up_sum = {1'b0, cur} + {1'b0, step};
        w_gap_dn = cur - tgt;
        next     = tgt;
        if (tgt > cur) begin
            if (w_up_sum < {1'b0, tgt}) begin
                next = w_up_sum[CNT_W-1:0];
            end
        end else if (cur > tgt) begin
            if (w_gap_dn > step) begin
                next = cur - step;
            end
        end
        // Without ramping the target is taken in a single jump
        if (RAMP_EN == 0) begin
            next = tgt;
        end
        done = (next == tgt);
    end

endmodule : duty_ramp_step
`default_nettype wire

// File: rtl/pwm_ramp_gen.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_ramp_gen
//  Description : PWM generator driven by an external free-running wrap
//                counter. Duty targets arrive over a valid/ready channel and
//                are applied only at period boundaries, ramping by STEP per
//                period (soft start / soft change).
//  Revision    : 1.0 - initial release
// ============================================================================
module pwm_ramp_gen
    import pwm_ramp_gen_pkg::*;
#(
    parameter int CNT_W   = CNT_W_DEF,
    parameter int STEP    = 16,
    parameter int RAMP_EN = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [CNT_W-1:0] cnt,
    input  logic             en,
    pwm_ramp_gen_if.slave    duty_if,
    output logic             pwm_out,
    output logic             period_end,
    output logic             busy,
    output logic [CNT_W-1:0] duty_act
);

    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] c_STEP    = CNT_W'(STEP);

    // Handshake / target registers
    logic [CNT_W-1:0] r_target;
    logic [CNT_W-1:0] r_pend;
    logic             r_pend_valid;
    logic             r_duty_ready;

    // Duty control FSM and registered outputs
    state_t           r_state;
    logic [CNT_W-1:0] r_duty_act;
    logic             r_busy;
    logic             r_pwm_out;
    logic             r_period_end;

    logic             w_bnd;
    logic             w_accept;
    logic [CNT_W-1:0] w_tgt_res;
    logic [CNT_W-1:0] w_step_next;
    logic             w_step_done;

    // Boundary detect, transfer detect and the target that a boundary edge
    // resolves to: a coincident transfer bypasses pend, otherwise a pending
    // value wins over the stored target.
    always_comb begin
        w_bnd     = (cnt == c_CNT_MAX);
        w_accept  = duty_if.duty_valid && r_duty_ready;
        w_tgt_res = r_target;
        if (w_accept) begin
            w_tgt_res = duty_if.duty_in;
        end else if (r_pend_valid) begin
            w_tgt_res = r_pend;
        end
    end

    duty_ramp_step #(
        .CNT_W   (CNT_W),
        .RAMP_EN (RAMP_EN)
    ) u_step (
        .cur  (r_duty_act),
        .tgt  (w_tgt_res),
        .step (c_STEP),
        .next (w_step_next),
        .done (w_step_done)
    );

    // Duty load channel: park an accepted value in pend until the boundary,
    // where it (or a coincident transfer) becomes the target
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_target     <= '0;
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_duty_ready <= 1'b1;
        end else if (w_bnd) begin
            r_target     <= w_tgt_res;
            r_pend_valid <= 1'b0;
            r_duty_ready <= 1'b1;
        end else if (w_accept) begin
            r_pend       <= duty_if.duty_in;
            r_pend_valid <= 1'b1;
            r_duty_ready <= 1'b0;
        end
    end

    // Duty FSM: disable wins immediately, otherwise duty moves only at bnd
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_duty_act <= '0;
            r_busy     <= 1'b0;
        end else if (!en) begin
            r_state    <= ST_IDLE;
            r_duty_act <= '0;
            r_busy     <= 1'b0;
        end else if (w_bnd) begin
            unique case (r_state)
                ST_IDLE: begin
                    // Leave IDLE at duty 0; ramping starts on the next period
                    r_duty_act <= '0;
                    if (w_tgt_res == '0) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_RAMP;
                        r_busy  <= 1'b1;
                    end
                end
                ST_RAMP, ST_RUN: begin
                    // In RUN with an unchanged target the step is a no-op
                    // and done holds the FSM in RUN
                    r_duty_act <= w_step_next;
                    if (w_step_done) begin
                        r_state <= ST_RUN;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_RAMP;
                        r_busy  <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_duty_act <= '0;
                    r_busy     <= 1'b0;
                end
            endcase
        end
    end

    // Registered PWM compare and period pulse; en gating forces the output
    // low on the same edge the FSM is sent to IDLE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pwm_out    <= 1'b0;
            r_period_end <= 1'b0;
        end else begin
            r_pwm_out    <= en && (r_state != ST_IDLE) && (cnt < r_duty_act);
            r_period_end <= w_bnd;
        end
    end

    assign duty_if.duty_ready = r_duty_ready;
    assign pwm_out            = r_pwm_out;
    assign period_end         = r_period_end;
    assign busy               = r_busy;
    assign duty_act           = r_duty_act;

endmodule : pwm_ramp_gen
`default_nettype wire
